// File: rtl/string_cmp_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the string-compare sequencer.
// Register addresses, control/status bit positions and the sequencer state type live here.
package string_hw_pkg;

    localparam logic [2:0] ADDR_PUSH_A = 3'd0;
    localparam logic [2:0] ADDR_PUSH_B = 3'd1;
    localparam logic [2:0] ADDR_CTRL   = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_RESULT = 3'd4;

    localparam int CTRL_GO    = 0;
    localparam int CTRL_CLEAR = 1;
    localparam int CTRL_IE    = 2;

    localparam int ST_BUSY  = 0;
    localparam int ST_DONE  = 1;
    localparam int ST_EQ    = 2;
    localparam int ST_LT    = 3;
    localparam int ST_GT    = 4;
    localparam int ST_ERR   = 5;
    localparam int ST_OVF_A = 6;
    localparam int ST_OVF_B = 7;
    localparam int ST_CNT_A = 8;
    localparam int ST_CNT_B = 12;

    typedef enum logic [1:0] {IDLE, FETCH, CMP, DONE} seq_state_t;

    typedef struct packed {
        logic ovf_b;
        logic ovf_a;
        logic err;
        logic gt;
        logic lt;
        logic eq;
        logic done;
    } seq_flags_t;

    // The status count fields are only 4 bits wide, so larger FIFOs report 15.
    function automatic logic [3:0] sat_count(input logic [31:0] c);
        return (c > 32'd15) ? 4'hF : c[3:0];
    endfunction

endpackage

// File: rtl/string_cmp_sequencer_if.sv
// Avalon-MM slave bus bundle for the string-compare sequencer.
interface string_cmp_sequencer_if;
    logic        chipselect;
    logic [2:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        irq;

    modport master (output chipselect, address, write, writedata, read,
                    input  readdata, irq);
    modport slave  (input  chipselect, address, write, writedata, read,
                    output readdata, irq);
endinterface

// File: rtl/string_cmp_sequencer_word_fifo.sv
// Show-ahead word FIFO holding one operand string; push and pop may coincide even when full.
module word_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [31:0]   din,
    output logic [31:0]   dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [31:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/string_cmp_sequencer.sv
// Avalon-MM controller that pops operand word pairs and compares them bytewise, MSB byte first.
// Result and status registers are polled by the host; irq is done gated by ie.
module string_cmp_sequencer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    string_cmp_sequencer_if.slave   bus
);
    import string_hw_pkg::*;

    seq_state_t  state_q, state_d;
    seq_flags_t  flags_q, flags_d;
    logic [13:0] wc_q, wc_d;
    logic [15:0] result_q, result_d;
    logic [31:0] a_word_q, a_word_d, b_word_q, b_word_d;
    logic [31:0] readdata_q, readdata_d;
    logic        ie_q, ie_d;

    logic        wr_a, wr_b, wr_ctrl, rd, go, clear, pop, busy;
    logic [31:0] dout_a, dout_b, status;
    logic        full_a, full_b, empty_a, empty_b;
    logic [AW:0] cnt_a, cnt_b;
    logic        mm_hit, mm_gt, nul_hit;
    logic [1:0]  mm_k, nul_k;

    assign wr_a    = bus.chipselect && bus.write && (bus.address == ADDR_PUSH_A);
    assign wr_b    = bus.chipselect && bus.write && (bus.address == ADDR_PUSH_B);
    assign wr_ctrl = bus.chipselect && bus.write && (bus.address == ADDR_CTRL);
    assign rd      = bus.chipselect && bus.read;
    assign go      = wr_ctrl && bus.writedata[CTRL_GO];
    assign clear   = wr_ctrl && bus.writedata[CTRL_CLEAR];
    assign busy    = (state_q == FETCH) || (state_q == CMP);

    word_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo_a (
        .clk(clk), .rst_n(reset_n), .push(wr_a && !clear), .pop(pop), .flush(clear),
        .din(bus.writedata), .dout(dout_a), .full(full_a), .empty(empty_a), .count(cnt_a)
    );

    word_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo_b (
        .clk(clk), .rst_n(reset_n), .push(wr_b && !clear), .pop(pop), .flush(clear),
        .din(bus.writedata), .dout(dout_b), .full(full_b), .empty(empty_b), .count(cnt_b)
    );

    // Descending scan so the lowest byte index (MSB byte) is the one left standing.
    always_comb begin
        mm_hit  = 1'b0;
        mm_gt   = 1'b0;
        mm_k    = 2'd0;
        nul_hit = 1'b0;
        nul_k   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (a_word_q[8*(3-k) +: 8] != b_word_q[8*(3-k) +: 8]) begin
                mm_hit = 1'b1;
                mm_k   = 2'(k);
                mm_gt  = a_word_q[8*(3-k) +: 8] > b_word_q[8*(3-k) +: 8];
            end
            if (a_word_q[8*(3-k) +: 8] == 8'h00) begin
                nul_hit = 1'b1;
                nul_k   = 2'(k);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        flags_d  = flags_q;
        wc_d     = wc_q;
        result_d = result_q;
        a_word_d = a_word_q;
        b_word_d = b_word_q;
        pop      = 1'b0;
        ie_d     = ie_q;
        if (wr_ctrl && !bus.writedata[CTRL_CLEAR]) ie_d = bus.writedata[CTRL_IE];

        case (state_q)
            IDLE, DONE: begin
                if (go) begin
                    state_d      = FETCH;
                    wc_d         = '0;
                    flags_d.done = 1'b0;
                    flags_d.eq   = 1'b0;
                    flags_d.lt   = 1'b0;
                    flags_d.gt   = 1'b0;
                    flags_d.err  = 1'b0;
                end
            end
            FETCH: begin
                if (!empty_a && !empty_b) begin
                    pop      = 1'b1;
                    a_word_d = dout_a;
                    b_word_d = dout_b;
                    state_d  = CMP;
                end else begin
                    flags_d.err  = 1'b1;
                    flags_d.done = 1'b1;
                    state_d      = DONE;
                end
            end
            CMP: begin
                if (mm_hit) begin
                    flags_d.gt   = mm_gt;
                    flags_d.lt   = !mm_gt;
                    flags_d.done = 1'b1;
                    result_d     = {wc_q, mm_k};
                    state_d      = DONE;
                end else if (nul_hit) begin
                    flags_d.eq   = 1'b1;
                    flags_d.done = 1'b1;
                    result_d     = {wc_q, nul_k};
                    state_d      = DONE;
                end else begin
                    wc_d    = wc_q + 14'd1;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_a && full_a && !pop) flags_d.ovf_a = 1'b1;
        if (wr_b && full_b && !pop) flags_d.ovf_b = 1'b1;

        // Clear aborts everything in flight but leaves the interrupt enable alone.
        if (clear) begin
            state_d  = IDLE;
            flags_d  = '0;
            wc_d     = '0;
            result_d = '0;
            pop      = 1'b0;
        end
    end

    always_comb begin
        status                    = '0;
        status[ST_BUSY]           = busy;
        status[ST_DONE]           = flags_q.done;
        status[ST_EQ]             = flags_q.eq;
        status[ST_LT]             = flags_q.lt;
        status[ST_GT]             = flags_q.gt;
        status[ST_ERR]            = flags_q.err;
        status[ST_OVF_A]          = flags_q.ovf_a;
        status[ST_OVF_B]          = flags_q.ovf_b;
        status[ST_CNT_A +: 4]     = sat_count(32'(cnt_a));
        status[ST_CNT_B +: 4]     = sat_count(32'(cnt_b));

        readdata_d = readdata_q;
        if (rd) begin
            case (bus.address)
                ADDR_CTRL:   readdata_d = {29'd0, ie_q, 2'b00};
                ADDR_STATUS: readdata_d = status;
                ADDR_RESULT: readdata_d = {16'd0, result_q};
                default:     readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            flags_q    <= '0;
            wc_q       <= '0;
            result_q   <= '0;
            a_word_q   <= '0;
            b_word_q   <= '0;
            readdata_q <= '0;
            ie_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            flags_q    <= flags_d;
            wc_q       <= wc_d;
            result_q   <= result_d;
            a_word_q   <= a_word_d;
            b_word_q   <= b_word_d;
            readdata_q <= readdata_d;
            ie_q       <= ie_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = flags_q.done && ie_q;

endmodule

// File: tb/tb_string_cmp_sequencer.sv
// Self-checking bench: queue-based string-compare model versus the sequencer, directed and random runs.
module tb_string_cmp_sequencer;

    localparam int DEPTH = 4;
    localparam logic [31:0] ABCD = 32'h61626364;
    localparam logic [31:0] ABCA = 32'h61626361;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    string_cmp_sequencer_if bus();

    string_cmp_sequencer #(.DEPTH(DEPTH), .AW(2)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: operand queues plus the flags the host should see.
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    bit m_ovf_a, m_ovf_b, m_ie, m_done, m_eq, m_lt, m_gt, m_err;
    logic [15:0] m_result;
    int m_pairs, m_exp, pre_a, pre_b;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic cs, input logic [2:0] addr, input logic wr,
                                 input logic [31:0] wd, input logic rd);
        @(negedge clk);
        bus.chipselect = cs;
        bus.address    = addr;
        bus.write      = wr;
        bus.writedata  = wd;
        bus.read       = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 3'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic readReg(input logic [2:0] addr, output logic [31:0] data);
        applyStimulus(1'b1, addr, 1'b0, 32'd0, 1'b1);
        data = bus.readdata;
    endtask

    task automatic pushA(input logic [31:0] w);
        applyStimulus(1'b1, 3'd0, 1'b1, w, 1'b0);
        if (qa.size() < DEPTH) qa.push_back(w); else m_ovf_a = 1'b1;
    endtask

    task automatic pushB(input logic [31:0] w);
        applyStimulus(1'b1, 3'd1, 1'b1, w, 1'b0);
        if (qb.size() < DEPTH) qb.push_back(w); else m_ovf_b = 1'b1;
    endtask

    task automatic doClear();
        applyStimulus(1'b1, 3'd2, 1'b1, 32'h2, 1'b0);
        qa.delete();
        qb.delete();
        {m_ovf_a, m_ovf_b, m_done, m_eq, m_lt, m_gt, m_err} = '0;
        m_result = '0;
    endtask

    task automatic setIe(input bit ie);
        applyStimulus(1'b1, 3'd2, 1'b1, {29'd0, ie, 2'b00}, 1'b0);
        m_ie = ie;
    endtask

    function automatic logic [3:0] sat4(input int c);
        return (c > 15) ? 4'hF : 4'(c);
    endfunction

    function automatic logic [31:0] statusWord(input bit busy, input bit done, input bit eq,
                                               input bit lt, input bit gt, input bit err,
                                               input int ca, input int cb);
        logic [31:0] s;
        s = '0;
        s[0] = busy; s[1] = done; s[2] = eq; s[3] = lt; s[4] = gt; s[5] = err;
        s[6] = m_ovf_a; s[7] = m_ovf_b;
        s[11:8]  = sat4(ca);
        s[15:12] = sat4(cb);
        return s;
    endfunction

    function automatic logic [7:0] byteAt(input logic [31:0] w, input int k);
        return w[31-8*k -: 8];
    endfunction

    // Walk the queued strings word by word; a mismatch anywhere in a word beats a NUL in it.
    task automatic modelGo();
        int wc;
        int k_mm, k_nul;
        logic [31:0] a, b;
        {m_done, m_eq, m_lt, m_gt, m_err} = '0;
        m_pairs = 0;
        wc = 0;
        forever begin
            if (qa.size() == 0 || qb.size() == 0) begin
                m_err = 1'b1;
                break;
            end
            a = qa.pop_front();
            b = qb.pop_front();
            m_pairs++;
            k_mm = -1;
            k_nul = -1;
            for (int k = 0; k < 4; k++) begin
                if (k_mm < 0 && byteAt(a, k) != byteAt(b, k)) k_mm = k;
                if (k_nul < 0 && byteAt(a, k) == 8'h00) k_nul = k;
            end
            if (k_mm >= 0) begin
                if (byteAt(a, k_mm) > byteAt(b, k_mm)) m_gt = 1'b1; else m_lt = 1'b1;
                m_result = 16'(wc * 4 + k_mm);
                break;
            end
            if (k_nul >= 0) begin
                m_eq = 1'b1;
                m_result = 16'(wc * 4 + k_nul);
                break;
            end
            wc++;
        end
        m_done = 1'b1;
        m_exp = m_err ? 2 * m_pairs + 2 : 2 * m_pairs + 1;
    endtask

    // Issue go and poll status every cycle; optionally replace one poll with a second go.
    task automatic runGo(input int rego_at);
        logic [31:0] exp;
        logic [31:0] rdata;
        int pops;
        pre_a = qa.size();
        pre_b = qb.size();
        modelGo();
        applyStimulus(1'b1, 3'd2, 1'b1, {29'd0, m_ie, 2'b01}, 1'b0);
        for (int i = 1; i <= m_exp + 1; i++) begin
            if (i == rego_at) begin
                applyStimulus(1'b1, 3'd2, 1'b1, {29'd0, m_ie, 2'b01}, 1'b0);
            end else begin
                readReg(3'd3, rdata);
                pops = (i / 2 < m_pairs) ? i / 2 : m_pairs;
                if (i < m_exp)
                    exp = statusWord(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pre_a - pops, pre_b - pops);
                else
                    exp = statusWord(1'b0, 1'b1, m_eq, m_lt, m_gt, m_err, pre_a - m_pairs, pre_b - m_pairs);
                checkOutput($sformatf("status_cyc%0d", i), rdata, exp);
            end
            checkOutput($sformatf("irq_cyc%0d", i), {31'd0, bus.irq},
                        {31'd0, (m_ie && i >= m_exp - 1)});
        end
        readReg(3'd4, rdata);
        checkOutput("result", rdata, {16'd0, m_result});
    endtask

    function automatic logic [7:0] rbyte();
        return ($urandom % 8 == 0) ? 8'h00 : 8'(8'h61 + $urandom % 3);
    endfunction

    // Preload two word pairs, go, then stream six more pairs while the sequencer runs.
    task automatic streamEight(input bit abort);
        logic [31:0] w;
        applyStimulus(1'b1, 3'd0, 1'b1, ABCD, 1'b0);
        applyStimulus(1'b1, 3'd1, 1'b1, ABCD, 1'b0);
        applyStimulus(1'b1, 3'd0, 1'b1, ABCD, 1'b0);
        applyStimulus(1'b1, 3'd1, 1'b1, ABCD, 1'b0);
        applyStimulus(1'b1, 3'd2, 1'b1, {29'd0, m_ie, 2'b01}, 1'b0);
        for (int j = 2; j < 8; j++) begin
            w = (j == 7) ? 32'h0 : ABCD;
            applyStimulus(1'b1, 3'd0, 1'b1, w, 1'b0);
            applyStimulus(1'b1, 3'd1, 1'b1, w, 1'b0);
        end
        if (abort) begin
            idle();
            doClear();
        end
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] rdata;
        logic [31:0] wa, wb;
        int na, nb, k;
        bit seen;

        bus.chipselect = 1'b0;
        bus.address    = 3'd0;
        bus.write      = 1'b0;
        bus.writedata  = 32'd0;
        bus.read       = 1'b0;
        {m_ovf_a, m_ovf_b, m_ie, m_done, m_eq, m_lt, m_gt, m_err} = '0;
        m_result = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] reset state");
        readReg(3'd3, rdata);
        checkOutput("reset_status", rdata, 32'h0);
        readReg(3'd4, rdata);
        checkOutput("reset_result", rdata, 32'h0);
        checkOutput("reset_irq", {31'd0, bus.irq}, 32'h0);
        readReg(3'd2, rdata);
        checkOutput("reset_ctrl", rdata, 32'h0);

        $display("[TB] equal two-word strings");
        pushA(ABCD); pushA(32'h0); pushB(ABCD); pushB(32'h0);
        runGo(0);
        checkOutput("eq_cycles", 32'(m_exp), 32'd5);
        readReg(3'd3, rdata);
        checkOutput("eq_status", rdata, 32'h0000_0006);
        readReg(3'd4, rdata);
        checkOutput("eq_result", rdata, 32'd4);
        idle();
        checkOutput("readdata_hold", bus.readdata, 32'd4);

        $display("[TB] greater and less");
        pushA(ABCD); pushB(ABCA);
        runGo(0);
        readReg(3'd3, rdata);
        checkOutput("gt_status", rdata, 32'h0000_0012);
        readReg(3'd4, rdata);
        checkOutput("gt_result", rdata, 32'd3);
        pushA(ABCA); pushB(ABCD);
        runGo(0);
        readReg(3'd3, rdata);
        checkOutput("lt_status", rdata, 32'h0000_000A);

        $display("[TB] overflow and missing operand");
        doClear();
        for (int i = 0; i < 5; i++) pushA(ABCD);
        readReg(3'd3, rdata);
        checkOutput("ovf_status", rdata, 32'h0000_0440);
        pushB(ABCD);
        runGo(0);
        readReg(3'd3, rdata);
        checkOutput("err_status", rdata, 32'h0000_0362);
        readReg(3'd4, rdata);
        checkOutput("err_result", rdata, 32'd0);
        applyStimulus(1'b1, 3'd5, 1'b1, 32'hFFFF_FFFF, 1'b0);
        readReg(3'd5, rdata);
        checkOutput("addr5_read", rdata, 32'h0);

        $display("[TB] streaming compare");
        doClear();
        streamEight(1'b0);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            readReg(3'd3, rdata);
            seen = rdata[1];
        end
        checkOutput("stream_done_seen", {31'd0, seen}, 32'd1);
        readReg(3'd3, rdata);
        checkOutput("stream_status", rdata, 32'h0000_0006);
        readReg(3'd4, rdata);
        checkOutput("stream_result", rdata, 32'd28);

        $display("[TB] clear mid-compare");
        doClear();
        streamEight(1'b1);
        readReg(3'd3, rdata);
        checkOutput("clear_status", rdata, 32'h0);
        checkOutput("clear_irq", {31'd0, bus.irq}, 32'h0);
        readReg(3'd4, rdata);
        checkOutput("clear_result", rdata, 32'h0);
        runGo(0);

        $display("[TB] interrupt and go while busy");
        doClear();
        setIe(1'b1);
        readReg(3'd2, rdata);
        checkOutput("ctrl_ie", rdata, 32'h4);
        pushA(ABCD); pushB(ABCD); pushA(ABCD); pushB(ABCD);
        pushA(ABCD); pushB(ABCD); pushA(32'h0); pushB(32'h0);
        runGo(3);
        readReg(3'd4, rdata);
        checkOutput("rego_result", rdata, 32'd12);
        checkOutput("rego_irq", {31'd0, bus.irq}, 32'd1);
        doClear();
        readReg(3'd2, rdata);
        checkOutput("clear_keeps_ie", rdata, 32'h4);

        $display("[TB] random compares");
        for (int it = 0; it < 40; it++) begin
            if ($urandom % 4 == 0) doClear();
            if ($urandom % 3 == 0) setIe(1'($urandom % 2));
            na = $urandom_range(0, 5);
            nb = $urandom_range(0, 5);
            for (int j = 0; j < ((na > nb) ? na : nb); j++) begin
                wa = {rbyte(), rbyte(), rbyte(), rbyte()};
                wb = wa;
                if ($urandom % 4 == 0) begin
                    k = $urandom_range(0, 3);
                    wb[31-8*k -: 8] = rbyte();
                end
                if (j < na) pushA(wa);
                if (j < nb) pushB(wb);
            end
            runGo(0);
        end

        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
